// File: rtl/sample_arbiter.sv
// Shares one capture register among NREQ requesters. A programmable period
// counter produces sample ticks, and each tick grants one pending requester in round-robin order.
module sample_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int CW   = 3,
    parameter int IW   = 2,
    parameter int MW   = 8
) (
    input  logic               clk,
    input  logic               res,
    input  logic               en,
    input  logic [CW-1:0]      period,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] val_in,
    output logic [NREQ-1:0]    gnt,
    output logic [DW-1:0]      val_out,
    output logic               val_vld,
    output logic [IW-1:0]      owner,
    output logic [MW-1:0]      miss_cnt
);

    logic [CW-1:0] cnt;
    logic [IW-1:0] last;
    logic          tick;
    logic          found;
    logic [IW-1:0] win;
    logic [IW-1:0] idx;

    // Comparing with ">=" lets a lowered period wrap at once instead of running to 2**CW.
    assign tick = en && (cnt >= period);

    // Round-robin search that starts one past the last winner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            cnt      <= '0;
            last     <= IW'(NREQ - 1);
            gnt      <= '0;
            val_out  <= '0;
            val_vld  <= 1'b0;
            owner    <= '0;
            miss_cnt <= '0;
        end else begin
            gnt     <= '0;
            val_vld <= 1'b0;
            if (en) begin
                cnt <= tick ? '0 : cnt + 1'b1;
                if (tick) begin
                    if (found) begin
                        gnt     <= NREQ'(1) << win;
                        val_out <= val_in[win*DW +: DW];
                        val_vld <= 1'b1;
                        owner   <= win;
                        last    <= win;
                    end else if (miss_cnt != {MW{1'b1}}) begin
                        miss_cnt <= miss_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sample_arbiter.sv
// Scoreboard bench for sample_arbiter. Directed scenarios push hand-computed grants
// tagged with the clock edge they must appear on. A monitor pops and compares each grant.
module tb_sample_arbiter;

    localparam int NREQ = 4, DW = 4, CW = 3, IW = 2, MW = 8;

    typedef struct {
        int              edge_no;
        logic [NREQ-1:0] gnt;
        logic [DW-1:0]   val;
        logic [IW-1:0]   owner;
    } exp_t;

    logic               clk = 1'b0;
    logic               res;
    logic               en;
    logic [CW-1:0]      period;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] val_in;
    logic [NREQ-1:0]    gnt;
    logic [DW-1:0]      val_out;
    logic               val_vld;
    logic [IW-1:0]      owner;
    logic [MW-1:0]      miss_cnt;

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    exp_t sb[$];

    sample_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW), .IW(IW), .MW(MW)) dut (
        .clk(clk), .res(res), .en(en), .period(period), .req(req), .val_in(val_in),
        .gnt(gnt), .val_out(val_out), .val_vld(val_vld), .owner(owner), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req_v);
        tests++;
        if (act !== req_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, req_v, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int e, input logic [NREQ-1:0] g, input logic [DW-1:0] v,
                        input logic [IW-1:0] o);
        exp_t x;
        x.edge_no = e; x.gnt = g; x.val = v; x.owner = o;
        sb.push_back(x);
    endtask

    // Monitor: checks invariants every cycle and pops the scoreboard on each grant.
    always @(negedge clk) begin
        if (res === 1'b0) begin
            check("vld_eq_or_gnt", int'(val_vld), int'(|gnt));
            check("gnt_onehot0", int'($onehot0(gnt)), 1);
            if (gnt !== '0 || val_vld === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_grant", int'(gnt), 0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("grant_edge", cyc, x.edge_no);
                    check("gnt", int'(gnt), int'(x.gnt));
                    check("val_out", int'(val_out), int'(x.val));
                    check("owner", int'(owner), int'(x.owner));
                end
            end
        end
    end

    initial begin
        int b;
        res = 1'b1; en = 1'b0; period = '0; req = '0; val_in = 16'hDCBA;

        // Reset, then idle with period 3: four missed ticks, no grants.
        step(2);
        check("rst_gnt", int'(gnt), 0);
        check("rst_val_out", int'(val_out), 0);
        check("rst_vld", int'(val_vld), 0);
        check("rst_owner", int'(owner), 0);
        check("rst_miss", int'(miss_cnt), 0);
        res = 1'b0; en = 1'b1; period = 3'd3;
        step(16);
        check("idle_miss", int'(miss_cnt), 4);
        check("idle_val_out", int'(val_out), 0);

        // Round robin, tick every cycle, all requesting.
        b = cyc;
        push(b+1, 4'b0001, 4'hA, 2'd0);
        push(b+2, 4'b0010, 4'hB, 2'd1);
        push(b+3, 4'b0100, 4'hC, 2'd2);
        push(b+4, 4'b1000, 4'hD, 2'd3);
        push(b+5, 4'b0001, 4'hA, 2'd0);
        period = 3'd0; req = 4'b1111;
        step(5);
        en = 1'b0; req = '0;
        step(2);

        // Skip and wrap: grant 2, then 0 (wrapping past 3), then 2 again.
        b = cyc;
        push(b+2, 4'b0100, 4'hC, 2'd2);
        push(b+4, 4'b0001, 4'hA, 2'd0);
        push(b+6, 4'b0100, 4'hC, 2'd2);
        en = 1'b1; period = 3'd1; req = 4'b0100;
        step(2);
        req = 4'b0101;
        step(4);
        en = 1'b0; req = '0;
        step(2);

        // Period lowered from 7 to 2 while cnt is 5.
        b = cyc;
        push(b+6,  4'b0001, 4'hA, 2'd0);
        push(b+9,  4'b0001, 4'hA, 2'd0);
        push(b+12, 4'b0001, 4'hA, 2'd0);
        en = 1'b1; period = 3'd7; req = 4'b0001;
        step(5);
        period = 3'd2;
        step(7);
        en = 1'b0; req = '0;
        step(2);

        // en gating: cnt frozen at 2 with period 3, grant after release.
        period = 3'd3; en = 1'b1;
        step(2);
        en = 1'b0; req = 4'b0010;
        step(10);
        b = cyc;
        push(b+2, 4'b0010, 4'hB, 2'd1);
        en = 1'b1;
        step(2);
        en = 1'b0; req = '0;
        step(1);
        check("gate_miss", int'(miss_cnt), 4);

        // Saturate miss_cnt, then reset in a tick cycle with a request.
        period = 3'd0; en = 1'b1;
        step(260);
        check("miss_sat", int'(miss_cnt), 255);
        step(3);
        check("miss_hold", int'(miss_cnt), 255);
        req = 4'b0001; res = 1'b1;
        step(1);
        check("rst2_gnt", int'(gnt), 0);
        check("rst2_vld", int'(val_vld), 0);
        check("rst2_val_out", int'(val_out), 0);
        check("rst2_owner", int'(owner), 0);
        check("rst2_miss", int'(miss_cnt), 0);
        res = 1'b0;
        b = cyc;
        push(b+1, 4'b0001, 4'hA, 2'd0);
        step(1);
        en = 1'b0; req = '0;
        step(3);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sample_arbiter.md
Name: sample_arbiter

Overview:
- Scheduler sharing one capture register (val_out) among NREQ requesters.
- A programmable period counter produces a sample tick. On each tick, one pending requester is granted in round-robin order, and its value is loaded into the shared register.
- Generalises the single-source "capture on counter rollover" path into a multi-source, period-programmable one.
- Sits between the requesting front-end blocks and the consumer of val_out.

Parameters:
- NREQ, 4, number of requesters (>=2).
- DW, 4, data width per requester and of val_out.
- CW, 3, period counter width.
- IW, 2, owner index width; must satisfy 2**IW >= NREQ.
- MW, 8, missed-tick counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- res  in  1  reset; synchronous, active-high.
- en  in  1  run enable; low freezes period counter and suppresses grants.
- period  in  CW  tick interval minus one; a tick occurs every period+1 enabled cycles.
- req  in  NREQ  per-requester request level; requester holds req and its data until granted.
- val_in  in  NREQ*DW  packed data; requester i occupies bits [i*DW+DW-1 : i*DW].
- gnt  out  NREQ  one-hot grant pulse, 1 cycle.
- val_out  out  DW  captured value of the last granted requester.
- val_vld  out  1  1-cycle pulse; val_out updated this cycle.
- owner  out  IW  index of last granted requester.
- miss_cnt  out  MW  saturating count of ticks that found no request.

Behaviour:
- Reset (res=1 at a clk edge):
  - cnt=0, gnt=0, val_out=0, val_vld=0, owner=0, miss_cnt=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority first.
  - Reset overrides all other inputs, including a tick in the same cycle.
- Period counter (en=1):
  - tick = (cnt >= period).
  - On tick, cnt<=0; else cnt<=cnt+1.
  - period=0 gives a tick every cycle.
  - If period is lowered below the current cnt, the ">=" forces a tick and wrap on the next evaluation; no 2**CW-long run-away.
- en=0: cnt holds, tick is forced 0, gnt/val_vld are 0, val_out/owner/miss_cnt hold.
- Arbitration:
  - Evaluated combinationally in the tick cycle t using req sampled at t.
  - Winner is the first i with req[i]=1, searching from last+1 upward with wrap modulo NREQ.
- Grant (registered, visible at t+1):
  - gnt[w]=1 for exactly one cycle.
  - val_out <= val_in slice w captured at t.
  - val_vld=1 for one cycle; owner<=w; last<=w.
  - Latency: tick cycle to gnt/val_vld is exactly 1 cycle.
- No request at tick:
  - No grant, val_out/owner/last unchanged.
  - miss_cnt increments, saturating at 2**MW-1 (no wrap).
- Non-tick cycles:
  - gnt=0 and val_vld=0; requests wait for the next tick (no queueing beyond the req level).
- Requester side:
  - May drop req only after seeing its gnt.
  - A req deasserted before a tick is simply not considered.
- Invariants:
  - gnt is zero or one-hot at all times.
  - val_vld == |gnt.
  - Back-to-back ticks (period=0) rotate grants every cycle among active requesters.
- Single active requester: it wins every tick regardless of last.
- Reset mid-operation: a pending grant from the tick in the reset cycle is discarded; the first post-reset tick occurs period+1 enabled cycles after reset release.

Test Plan:
- Reset then idle: res=1 for 2 cycles, then en=1, period=3, req=0 for 16 cycles -> ticks at 4-cycle spacing, gnt never asserted, val_out=0, miss_cnt=4.
- Round-robin fairness: period=0, req=4'b1111, val_in={4'hD,4'hC,4'hB,4'hA} -> successive grants to 0,1,2,3,0…; val_out sequence A,B,C,D,A; val_vld high every cycle after the first.
- Skip and wrap: period=1, last=2 (after granting idx2), req=4'b0101 -> next grant idx0 (wrap past 3); following tick grants idx2.
- Period change mid-count: period=7, let cnt reach 5, set period=2 -> tick on the next cycle (cnt>=period), then ticks every 3 cycles.
- en gating: en=0 for 10 cycles with req=4'b0010 -> cnt frozen, no gnt; en=1 -> gnt[1] at the first tick after remaining count, val_out=slice1.
- Saturation and reset mid-grant: period=0, req=0 for 260 cycles -> miss_cnt=255 held; then req=4'b0001 with res=1 in the tick cycle -> no gnt next cycle, all outputs 0.
